// File: rtl/rf_pkg.sv
// Shared widths and types for the register-file writeback path.
// The arbiter priority encoding is also the state of the round-robin arbiter.
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RF_ADDR_W  = 6;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } wb_pri_e;

  // One writeback transfer as it crosses from a source into the output stage.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter: index 0 is the ALU, index 1 the LSU.
// A lone request is always granted; a tie goes to the favoured side, which then flips.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  wb_pri_e pri_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || pri_q == PRI_ALU)) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
  end

  // A granted request is always accepted, so a tie here is an accepted tie.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_ALU;
    end else if (&req_i) begin
      pri_q <= gnt_o[0] ? PRI_LSU : PRI_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register file's single write port: arbitrates ALU/LSU writebacks,
// registers the winner for one cycle, and tracks pending writes in a busy scoreboard.
module regfile_wb_arbiter
  import rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  alloc_valid,
  input  logic [REG_ADDR_W-1:0] alloc_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [RF_ADDR_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  logic [1:0]          gnt;
  logic                alu_acc;
  logic                lsu_acc;
  wb_req_t             win;
  logic                we_d,    we_q;
  logic [REG_ADDR_W-1:0] waddr_d, waddr_q;
  logic [XLEN-1:0]     wdata_d, wdata_q;
  logic [NUM_REGS-1:0] busy_d,  busy_q;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({lsu_valid, alu_valid}),
    .gnt_o (gnt)
  );

  // Ready is a pure function of valids and arbiter state, held low through reset.
  assign alu_ready = gnt[0] & rst_n;
  assign lsu_ready = gnt[1] & rst_n;
  assign alu_acc   = alu_valid & alu_ready;
  assign lsu_acc   = lsu_valid & lsu_ready;

  always_comb begin
    win     = alu_acc ? wb_req_t'{rd: alu_rd, data: alu_data}
                      : wb_req_t'{rd: lsu_rd, data: lsu_data};
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    // Writes to x0 complete the handshake but never reach the port.
    if ((alu_acc || lsu_acc) && win.rd != '0) begin
      we_d    = 1'b1;
      waddr_d = win.rd;
      wdata_d = win.data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[waddr_q] = 1'b0;
    end
    // Applied after the clear so a same-edge re-allocation keeps the bit set.
    if (alloc_valid && alloc_rd != '0) begin
      busy_d[alloc_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = {1'b0, waddr_q};
  assign rf_wdata = wdata_q;
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule
